// File: rtl/gamepad_scanner_pkg.sv
// Shared definitions for the gamepad scanner.
//  - Button bit positions inside one pad's 12-bit word.
//  - Pin bit positions inside one pad's 6-bit pin group.
//  - Scan FSM state encoding.
package gamepad_scanner_pkg;

  localparam int BTN_W = 12;
  localparam int PIN_W = 6;

  // Button word, LSB first: Up,Down,Left,Right,B,C,A,Start,Z,Y,X,Mode
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  // Pin group, LSB first: Pino1,Pino2,Pino3,Pino4,Pino6,Pino9
  localparam int PIN_1 = 0;
  localparam int PIN_2 = 1;
  localparam int PIN_3 = 2;
  localparam int PIN_4 = 3;
  localparam int PIN_6 = 4;
  localparam int PIN_9 = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/gamepad_scanner_if.sv
// Pad/video-side bundle of the gamepad scanner.
//  v_sync      : VGA vertical sync, active-low, its falling edge starts a scan
//  Pinos       : raw pad pins, 6 per pad, active-low
//  Select      : shared pad select line, idle high
//  Saidas      : debounced button levels, 12 per pad, 1 = pressed
//  Pressionado : one-cycle press pulses, 12 per pad
//  Presente    : pad detected on the last scan, 1 per pad
//  SeisBotoes  : pad identified as 6-button on the last scan, 1 per pad
//  scan_done   : one-cycle pulse when the outputs update
//  overrun     : sticky, v_sync edge seen while a scan was running
// master = the pads/video side, slave = the scanner.
interface gamepad_scanner_if #(
  parameter int N_PADS = 2
);
  import gamepad_scanner_pkg::*;

  logic                    v_sync;
  logic [PIN_W*N_PADS-1:0] Pinos;
  logic                    Select;
  logic [BTN_W*N_PADS-1:0] Saidas;
  logic [BTN_W*N_PADS-1:0] Pressionado;
  logic [N_PADS-1:0]       Presente;
  logic [N_PADS-1:0]       SeisBotoes;
  logic                    scan_done;
  logic                    overrun;

  modport master (
    output v_sync, Pinos,
    input  Select, Saidas, Pressionado, Presente, SeisBotoes, scan_done, overrun
  );

  modport slave (
    input  v_sync, Pinos,
    output Select, Saidas, Pressionado, Presente, SeisBotoes, scan_done, overrun
  );

endinterface

// File: rtl/gamepad_scanner_pad_debounce.sv
// Per-pad button debouncer.
//  clk, rst_n : clock, asynchronous active-low reset
//  update     : one-cycle strobe, a new raw scan result is valid
//  raw        : this scan's decoded buttons, 1 = pressed
//  held       : debounced levels
//  pressed    : one-cycle pulse on each held 0->1 change, aligned with the commit
// A held bit only follows raw after DEBOUNCE_FRAMES consecutive scans that disagree
// with it; any agreeing scan restarts the count.
module pad_debounce
  import gamepad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             update,
  input  logic [BTN_W-1:0] raw,
  output logic [BTN_W-1:0] held,
  output logic [BTN_W-1:0] pressed
);

  // The counter only needs to reach DEBOUNCE_FRAMES-1: the scan that would take it to
  // DEBOUNCE_FRAMES commits and clears instead.
  localparam int CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(DEBOUNCE_FRAMES - 1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  genvar gi;
  generate
    for (gi = 0; gi < BTN_W; gi++) begin : g_bit
      cnt_t cnt_reg;
      logic held_reg;
      logic pressed_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg     <= '0;
          held_reg    <= 1'b0;
          pressed_reg <= 1'b0;
        end else begin
          pressed_reg <= 1'b0;
          if (update) begin
            if (raw[gi] != held_reg) begin
              if (cnt_reg == CNT_LAST) begin
                held_reg    <= raw[gi];
                cnt_reg     <= '0;
                pressed_reg <= raw[gi];
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end else begin
              cnt_reg <= '0;
            end
          end
        end
      end

      assign held[gi]    = held_reg;
      assign pressed[gi] = pressed_reg;
    end
  endgenerate

endmodule

// File: rtl/gamepad_scanner.sv
// Multi-pad Mega Drive-style gamepad scanner.
//  Clock50 : system clock
//  Reset   : asynchronous active-low reset; aborts a scan in progress
//  bus     : gamepad_scanner_if.slave (v_sync, Pinos in; Select, Saidas,
//            Pressionado, Presente, SeisBotoes, scan_done, overrun out)
// Once per v_sync falling edge the shared Select line walks through P phases
// (8 for 6-button, 2 for 3-button), each SETTLE_CYCLES long; synchronised pins are
// sampled on the last clock of each phase and decoded per pad. One UPDATE clock then
// commits presence flags and feeds each pad's debouncer.
module gamepad_scanner
  import gamepad_scanner_pkg::*;
#(
  parameter int N_PADS          = 2,
  parameter int SIX_BUTTON      = 1,
  parameter int SETTLE_CYCLES   = 50,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic             Clock50,
  input  logic             Reset,
  gamepad_scanner_if.slave bus
);

  localparam int N_PHASES = (SIX_BUTTON != 0) ? 8 : 2;
  localparam int SET_W    = $clog2(SETTLE_CYCLES);
  typedef logic [SET_W-1:0] settle_t;
  localparam settle_t    SETTLE_LAST = settle_t'(SETTLE_CYCLES - 1);
  localparam settle_t    SETTLE_ONE  = settle_t'(1);
  localparam logic [2:0] PHASE_LAST  = 3'(N_PHASES - 1);

  // Synchronisers. v_sync idles high, so reset the chain high to avoid a false edge.
  logic [PIN_W*N_PADS-1:0] pins_meta_reg, pins_sync_reg;
  logic vs_meta_reg, vs_sync_reg, vs_prev_reg;

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      pins_meta_reg <= '1;
      pins_sync_reg <= '1;
      vs_meta_reg   <= 1'b1;
      vs_sync_reg   <= 1'b1;
      vs_prev_reg   <= 1'b1;
    end else begin
      pins_meta_reg <= bus.Pinos;
      pins_sync_reg <= pins_meta_reg;
      vs_meta_reg   <= bus.v_sync;
      vs_sync_reg   <= vs_meta_reg;
      vs_prev_reg   <= vs_sync_reg;
    end
  end

  logic vs_fall;
  assign vs_fall = vs_prev_reg & ~vs_sync_reg;

  // Scan FSM
  scan_state_t state_reg;
  logic [2:0]  phase_reg;
  settle_t     settle_reg;
  logic        select_reg;
  logic        scan_done_reg;
  logic        overrun_reg;

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= 3'd0;
      settle_reg    <= '0;
      select_reg    <= 1'b1;
      scan_done_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      scan_done_reg <= 1'b0;
      // Edges during a scan are dropped, only remembered here.
      if (vs_fall && state_reg != ST_IDLE) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (vs_fall) begin
            state_reg  <= ST_SCAN;
            phase_reg  <= 3'd0;
            settle_reg <= '0;
            select_reg <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (settle_reg == SETTLE_LAST) begin
            settle_reg <= '0;
            if (phase_reg == PHASE_LAST) begin
              state_reg  <= ST_UPDATE;
              select_reg <= 1'b1;
            end else begin
              phase_reg  <= phase_reg + 3'd1;
              // Select for phase k+1 is ~(k+1)[0], which equals k[0].
              select_reg <= phase_reg[0];
            end
          end else begin
            settle_reg <= settle_reg + SETTLE_ONE;
          end
        end
        ST_UPDATE: begin
          state_reg     <= ST_IDLE;
          phase_reg     <= 3'd0;
          scan_done_reg <= 1'b1;
        end
        default: begin
          state_reg  <= ST_IDLE;
          select_reg <= 1'b1;
        end
      endcase
    end
  end

  logic sample;
  logic update;
  assign sample = (state_reg == ST_SCAN) && (settle_reg == SETTLE_LAST);
  assign update = (state_reg == ST_UPDATE);

  assign bus.Select    = select_reg;
  assign bus.scan_done = scan_done_reg;
  assign bus.overrun   = overrun_reg;

  // Per-pad decode and debounce
  genvar gi;
  generate
    for (gi = 0; gi < N_PADS; gi++) begin : g_pad
      logic [PIN_W-1:0] pins;
      logic [BTN_W-1:0] raw_reg;
      logic [BTN_W-1:0] raw_masked;
      logic [BTN_W-1:0] held;
      logic [BTN_W-1:0] pressed;
      logic             present_reg;
      logic             six_reg;
      logic             presente_reg;
      logic             seis_reg;

      assign pins = pins_sync_reg[gi*PIN_W +: PIN_W];

      always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
          raw_reg      <= '0;
          present_reg  <= 1'b0;
          six_reg      <= 1'b0;
          presente_reg <= 1'b0;
          seis_reg     <= 1'b0;
        end else begin
          if (sample) begin
            case (phase_reg)
              // Select high: Up,Down,Left,Right,B,C map straight onto the pin group.
              // Everything else for this scan starts cleared here.
              3'd0: begin
                raw_reg     <= {{(BTN_W-PIN_W){1'b0}}, ~pins};
                present_reg <= 1'b0;
                six_reg     <= 1'b0;
              end
              // Select low: a connected pad grounds Pino3/Pino4.
              3'd1: begin
                raw_reg[BTN_A]     <= ~pins[PIN_6];
                raw_reg[BTN_START] <= ~pins[PIN_9];
                present_reg        <= ~pins[PIN_3] & ~pins[PIN_4];
              end
              // Third low phase: a 6-button pad grounds Pino1..4.
              3'd5: six_reg <= (pins[PIN_1 +: 4] == 4'b0000);
              // Following high phase: Z,Y,X,Mode on Pino1..4.
              3'd6: raw_reg[BTN_Z +: 4] <= six_reg ? ~pins[PIN_1 +: 4] : 4'b0000;
              default: ;
            endcase
          end
          if (update) begin
            presente_reg <= present_reg;
            seis_reg     <= present_reg & six_reg;
          end
        end
      end

      // An absent pad reads as nothing pressed, whatever its pins float to.
      assign raw_masked = present_reg ? raw_reg : '0;

      pad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
      ) u_debounce (
        .clk    (Clock50),
        .rst_n  (Reset),
        .update (update),
        .raw    (raw_masked),
        .held   (held),
        .pressed(pressed)
      );

      assign bus.Saidas[gi*BTN_W +: BTN_W]      = held;
      assign bus.Pressionado[gi*BTN_W +: BTN_W] = pressed;
      assign bus.Presente[gi]                   = presente_reg;
      assign bus.SeisBotoes[gi]                 = seis_reg;
    end
  endgenerate

endmodule

// File: tb/tb_gamepad_scanner.sv
// Testbench for gamepad_scanner: pad models that follow the Select line, a
// per-scan expectation queue and a monitor that checks every scan_done.
module tb_gamepad_scanner;
  import gamepad_scanner_pkg::*;

  localparam int N_PADS   = 2;
  localparam int SETTLE   = 8;
  localparam int DF       = 2;
  localparam int N_PH     = 8;
  // two synchroniser stages, edge seen by the FSM on the third clock, then P*SETTLE+1
  localparam int EXP_LAT  = 3 + N_PH*SETTLE + 1;

  localparam int PAD_SIX   = 0;
  localparam int PAD_THREE = 1;
  localparam int PAD_QUIRK = 2;  // 3-button that grounds Pino1..4 in phase 6
  localparam int PAD_NONE  = 3;

  typedef struct {
    logic [BTN_W*N_PADS-1:0] saidas;
    logic [BTN_W*N_PADS-1:0] press;
    logic [N_PADS-1:0]       pres;
    logic [N_PADS-1:0]       six;
    logic                    ovr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gamepad_scanner_if #(.N_PADS(N_PADS)) bus ();

  gamepad_scanner #(
    .N_PADS(N_PADS), .SIX_BUTTON(1), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_FRAMES(DF)
  ) dut (
    .Clock50(clk),
    .Reset  (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- pad models ----------------
  int          pad_mode [N_PADS] = '{PAD_NONE, PAD_NONE};
  logic [11:0] pad_btn  [N_PADS] = '{12'h0, 12'h0};

  // Phase counter as a real pad keeps it: one step per Select transition,
  // cleared after Select has idled high for a while.
  int   k_ph   = 0;
  int   hi_cnt = 0;
  logic sel_q  = 1'b1;

  always @(posedge clk) begin
    sel_q <= bus.Select;
    if (bus.Select !== sel_q) begin
      k_ph   <= k_ph + 1;
      hi_cnt <= 0;
    end else if (bus.Select === 1'b1) begin
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt > 3*SETTLE) k_ph <= 0;
    end
  end

  // Returns {P9,P6,P4,P3,P2,P1}, active-low.
  function automatic logic [5:0] pad_pins(input int mode, input logic [11:0] b, input int k);
    logic p1, p2, p3, p4, p6, p9;
    if (mode == PAD_NONE) return 6'h3F;
    if (k % 2 == 0) begin
      if (mode == PAD_SIX && k == 6)
        {p4, p3, p2, p1} = ~{b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
      else if (mode == PAD_QUIRK && k == 6)
        {p4, p3, p2, p1} = 4'b0000;
      else
        {p4, p3, p2, p1} = ~{b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP]};
      p6 = ~b[BTN_B];
      p9 = ~b[BTN_C];
    end else begin
      if (mode == PAD_SIX && k == 5)
        {p4, p3, p2, p1} = 4'b0000;
      else
        {p4, p3, p2, p1} = {2'b00, ~b[BTN_DOWN], ~b[BTN_UP]};
      p6 = ~b[BTN_A];
      p9 = ~b[BTN_START];
    end
    return {p9, p6, p4, p3, p2, p1};
  endfunction

  always_comb begin
    logic [PIN_W*N_PADS-1:0] v;
    v = '1;
    for (int p = 0; p < N_PADS; p++) v[p*PIN_W +: PIN_W] = pad_pins(pad_mode[p], pad_btn[p], k_ph);
    bus.Pinos = v;
  end

  // ---------------- reference model ----------------
  int          m_cnt  [N_PADS][BTN_W];
  logic [11:0] m_held [N_PADS];
  logic        m_ovr;
  exp_t        exp_q [$];

  task automatic model_reset();
    for (int p = 0; p < N_PADS; p++) begin
      m_held[p] = 12'h0;
      for (int b = 0; b < BTN_W; b++) m_cnt[p][b] = 0;
    end
    m_ovr = 1'b0;
  endtask

  task automatic model_scan(output exp_t e);
    logic [11:0] raw, nh;
    e.saidas = '0; e.press = '0; e.pres = '0; e.six = '0;
    for (int p = 0; p < N_PADS; p++) begin
      case (pad_mode[p])
        PAD_SIX:              raw = pad_btn[p];
        PAD_THREE, PAD_QUIRK: raw = pad_btn[p] & 12'h0FF;
        default:              raw = 12'h000;
      endcase
      nh = m_held[p];
      for (int b = 0; b < BTN_W; b++) begin
        if (raw[b] != m_held[p][b]) begin
          m_cnt[p][b]++;
          if (m_cnt[p][b] >= DF) begin
            nh[b] = raw[b];
            m_cnt[p][b] = 0;
          end
        end else begin
          m_cnt[p][b] = 0;
        end
      end
      e.press[p*BTN_W +: BTN_W]  = nh & ~m_held[p];
      e.saidas[p*BTN_W +: BTN_W] = nh;
      e.pres[p] = (pad_mode[p] != PAD_NONE);
      e.six[p]  = (pad_mode[p] == PAD_SIX);
      m_held[p] = nh;
    end
    e.ovr = m_ovr;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.scan_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_scan_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("Saidas", 32'(bus.Saidas), 32'(e.saidas));
          check("Pressionado", 32'(bus.Pressionado), 32'(e.press));
          check("Presente", 32'(bus.Presente), 32'(e.pres));
          check("SeisBotoes", 32'(bus.SeisBotoes), 32'(e.six));
          check("overrun", 32'(bus.overrun), 32'(e.ovr));
          $display("scan: Saidas=%h Pressionado=%h Presente=%b SeisBotoes=%b overrun=%b",
                   bus.Saidas, bus.Pressionado, bus.Presente, bus.SeisBotoes, bus.overrun);
        end
      end else begin
        check("press_outside_scan_done", 32'(bus.Pressionado), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_scan(input bit inject);
    exp_t e;
    int   n;
    bit   got;
    for (int p = 0; p < N_PADS; p++)
      if (pad_mode[p] != PAD_SIX && pad_btn[p][BTN_UP]) pad_btn[p][BTN_DOWN] = 1'b0;
    if (inject) m_ovr = 1'b1;
    model_scan(e);
    exp_q.push_back(e);
    @(negedge clk);
    bus.v_sync = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.scan_done === 1'b1) got = 1'b1;
      if (n == 4) bus.v_sync = 1'b1;
      if (inject && n == 20) bus.v_sync = 1'b0;
      if (inject && n == 24) bus.v_sync = 1'b1;
    end
    check("scan_latency", 32'(n), 32'(EXP_LAT));
    repeat (40 + $urandom_range(0, 15)) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_Select"}, 32'(bus.Select), 32'd1);
    check({tag, "_Saidas"}, 32'(bus.Saidas), 32'd0);
    check({tag, "_Pressionado"}, 32'(bus.Pressionado), 32'd0);
    check({tag, "_Presente"}, 32'(bus.Presente), 32'd0);
    check({tag, "_SeisBotoes"}, 32'(bus.SeisBotoes), 32'd0);
    check({tag, "_scan_done"}, 32'(bus.scan_done), 32'd0);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
  endtask

  initial begin
    bus.v_sync = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // Six-button pad holds A+Z; takes two scans to show up.
    pad_mode[0] = PAD_SIX; pad_btn[0] = 12'h140;
    pad_mode[1] = PAD_SIX; pad_btn[1] = 12'h000;
    run_scan(0);
    run_scan(0);
    // Three-button pad that grounds Pino1..4 in phase 6, extra bits must stay 0.
    pad_mode[1] = PAD_QUIRK; pad_btn[1] = 12'hF0D;
    run_scan(0);
    run_scan(0);
    // Pad 1 unplugged.
    pad_mode[1] = PAD_NONE;
    run_scan(0);
    run_scan(0);
    // B glitches for one scan only.
    pad_btn[0] = 12'h150;
    run_scan(0);
    pad_btn[0] = 12'h140;
    run_scan(0);
    // Second v_sync edge mid-scan.
    run_scan(1);
    run_scan(0);

    // Reset in phase 3 of a scan.
    @(negedge clk);
    bus.v_sync = 1'b0;
    repeat (4) @(negedge clk);
    bus.v_sync = 1'b1;
    repeat (3 + 3*SETTLE + 4 - 4) @(negedge clk);
    check("select_phase3", 32'(bus.Select), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    exp_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    begin
      bit sel_ok;
      sel_ok = 1'b1;
      repeat (100) begin
        @(negedge clk);
        if (bus.Select !== 1'b1 || bus.scan_done !== 1'b0) sel_ok = 1'b0;
      end
      check("idle_after_reset", 32'(sel_ok), 32'd1);
    end

    // Random traffic.
    for (int s = 0; s < 40; s++) begin
      for (int p = 0; p < N_PADS; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          int r;
          r = $urandom_range(0, 5);
          pad_mode[p] = (r <= 2) ? PAD_SIX : (r == 3) ? PAD_THREE : (r == 4) ? PAD_QUIRK : PAD_NONE;
          pad_btn[p]  = 12'($urandom);
        end
      end
      run_scan(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
